// File: rtl/benes_sel_loader_pkg.sv
// -----------------------------------------------------------------------------
// benes_sel_loader_pkg
// Shared types and constants for the Benes select loader.
//   DEF_SWITCH_NUM : switches per Benes stage (select-word width)
//   DEF_STAGE_NUM  : number of Benes stages
//   DEF_EPOCH_W    : width of the commit counter
//   SEL_STAGE_W    : width of a stage index
//   BenesSelBank   : one full set of per-stage select words
//   BenesLoadState : loader FSM states
// -----------------------------------------------------------------------------
package benes_sel_loader_pkg;

    localparam int DEF_SWITCH_NUM = 16;
    localparam int DEF_STAGE_NUM  = 9;
    localparam int DEF_EPOCH_W    = 8;
    localparam int SEL_STAGE_W    = $clog2(DEF_STAGE_NUM);

    typedef logic [DEF_SWITCH_NUM-1:0] BenesSelBank [0:DEF_STAGE_NUM-1];

    // LOAD: shadow banks accept beats. FULL: shadow complete, waiting for commit.
    typedef enum logic [0:0] {
        LOAD = 1'b0,
        FULL = 1'b1
    } BenesLoadState;

    // Position of a (target, stage) pair inside the written-mask.
    // Module-network stages occupy the low half, slot-network stages the high half.
    function automatic int unsigned mask_pos(input logic target, input int unsigned stage,
                                             input int unsigned stage_num);
        int unsigned pos;
        if (target) begin
            pos = stage_num + stage;
        end else begin
            pos = stage;
        end
        return pos;
    endfunction

endpackage

// File: rtl/benes_sel_loader_if.sv
// -----------------------------------------------------------------------------
// benes_sel_loader_if
// Configuration stream into the Benes select loader.
//   i_cfg_valid  : beat valid
//   o_cfg_ready  : loader accepting beats
//   i_cfg_target : 0 = module network, 1 = slot network
//   i_cfg_stage  : stage index of this beat
//   i_cfg_bits   : select word, bit k = switch k (1 = cross)
//   i_cfg_last   : final beat of the configuration
//   i_commit     : request to swap shadow into active
// Modports: master drives the stream (scheduler/software), slave is the loader.
// -----------------------------------------------------------------------------
interface benes_sel_loader_if #(
    parameter int SWITCH_NUM = 16,
    parameter int STAGE_W    = 4
);

    logic                  i_cfg_valid;
    logic                  o_cfg_ready;
    logic                  i_cfg_target;
    logic [STAGE_W-1:0]    i_cfg_stage;
    logic [SWITCH_NUM-1:0] i_cfg_bits;
    logic                  i_cfg_last;
    logic                  i_commit;

    modport master (
        output i_cfg_valid,
        output i_cfg_target,
        output i_cfg_stage,
        output i_cfg_bits,
        output i_cfg_last,
        output i_commit,
        input  o_cfg_ready
    );

    modport slave (
        input  i_cfg_valid,
        input  i_cfg_target,
        input  i_cfg_stage,
        input  i_cfg_bits,
        input  i_cfg_last,
        input  i_commit,
        output o_cfg_ready
    );

endinterface

// File: rtl/benes_sel_loader_bank.sv
// -----------------------------------------------------------------------------
// benes_sel_bank
// One shadow + active register pair for a single Benes network.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_bits into shadow stage wr_stage
//   wr_stage   : stage index of the write (must be < STAGE_NUM when wr_en)
//   wr_bits    : select word to store
//   swap       : copy the whole shadow bank into the active bank
//   active_sel : active selects, stage 0 first
// The active bank only ever changes on swap, so the interconnect never sees a
// half-written configuration.
// -----------------------------------------------------------------------------
module benes_sel_bank #(
    parameter int SWITCH_NUM = 16,
    parameter int STAGE_NUM  = 9,
    parameter int STAGE_W    = $clog2(STAGE_NUM)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [STAGE_W-1:0]                    wr_stage,
    input  logic [SWITCH_NUM-1:0]                 wr_bits,
    input  logic                                  swap,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]  active_sel
);

    logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] shadow_r;
    logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] active_r;

    // Shadow bank: per-stage write; stage decode compares against each index
    // so an out-of-range index can never alias onto a real stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
        end else begin
            for (int s = 0; s < STAGE_NUM; s++) begin
                if (wr_en && (32'(wr_stage) == s)) begin
                    shadow_r[s] <= wr_bits;
                end
            end
        end
    end

    // Active bank: whole-bank atomic copy from shadow on swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= '0;
        end else if (swap) begin
            active_r <= shadow_r;
        end
    end

    assign active_sel = active_r;

endmodule

// File: rtl/benes_sel_loader.sv
// -----------------------------------------------------------------------------
// benes_sel_loader
// Double-buffered select loader for the module-side and slot-side Benes
// networks. Beats fill the shadow banks; once every (target, stage) pair has
// been written and a last beat arrives, the loader waits in FULL for a commit,
// which swaps both shadows into the active banks in the same cycle.
//   clk, rst_n      : clock, asynchronous active-low reset
//   cfg             : configuration stream (slave side)
//   o_module_select : active module-network selects -> IntcBenesInputs.i_module_select
//   o_slot_select   : active slot-network selects   -> IntcBenesInputs.i_slot_select
//   o_epoch         : successful commits, modulo 2^EPOCH_W
//   o_cfg_error     : sticky error (bad stage index or incomplete last)
//   i_err_clr       : clears o_cfg_error (a simultaneous error event wins)
// -----------------------------------------------------------------------------
module benes_sel_loader
    import benes_sel_loader_pkg::*;
#(
    parameter int SWITCH_NUM = DEF_SWITCH_NUM,
    parameter int STAGE_NUM  = DEF_STAGE_NUM,
    parameter int EPOCH_W    = DEF_EPOCH_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    benes_sel_loader_if.slave                     cfg,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]  o_module_select,
    output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0]  o_slot_select,
    output logic [EPOCH_W-1:0]                    o_epoch,
    output logic                                  o_cfg_error,
    input  logic                                  i_err_clr
);

    localparam int STAGE_W = $clog2(STAGE_NUM);
    localparam int MASK_W  = 2 * STAGE_NUM;

    BenesLoadState         state_r;
    BenesLoadState         state_next_s;
    logic [MASK_W-1:0]     mask_r;
    logic [MASK_W-1:0]     mask_next_s;
    logic [MASK_W-1:0]     beat_bit_s;
    logic [MASK_W-1:0]     mask_upd_s;
    logic [EPOCH_W-1:0]    epoch_r;
    logic                  err_r;
    logic                  err_next_s;
    logic                  ready_r;

    logic                  beat_s;
    logic                  stage_ok_s;
    logic                  wr_s;
    logic                  last_s;
    logic                  complete_s;
    logic                  commit_s;
    logic                  err_set_s;
    logic                  wr_module_s;
    logic                  wr_slot_s;

    // Beat decode: acceptance, stage range check and the mask bit it would set.
    always_comb begin
        beat_s     = cfg.i_cfg_valid & ready_r;
        stage_ok_s = (32'(cfg.i_cfg_stage) < STAGE_NUM);
        wr_s       = beat_s & stage_ok_s;
        last_s     = beat_s & cfg.i_cfg_last;
        beat_bit_s = '0;
        for (int s = 0; s < STAGE_NUM; s++) begin
            if (wr_s && (32'(cfg.i_cfg_stage) == s)) begin
                beat_bit_s[mask_pos(cfg.i_cfg_target, s, STAGE_NUM)] = 1'b1;
            end else begin
                beat_bit_s = beat_bit_s;
            end
        end
        // Completeness includes the current beat so a last on the final
        // missing stage still counts as complete.
        mask_upd_s  = mask_r | beat_bit_s;
        complete_s  = &mask_upd_s;
        commit_s    = (state_r == FULL) & cfg.i_commit;
        wr_module_s = wr_s & ~cfg.i_cfg_target;
        wr_slot_s   = wr_s & cfg.i_cfg_target;
    end

    // Next-state decode: LOAD -> FULL on a complete last, FULL -> LOAD on commit.
    // A commit in LOAD is simply not looked at.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (last_s && complete_s) begin
                    state_next_s = FULL;
                end else begin
                    state_next_s = LOAD;
                end
            end
            FULL: begin
                if (commit_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: begin
                state_next_s = LOAD;
            end
        endcase
    end

    // Mask and error next values.
    always_comb begin
        mask_next_s = mask_upd_s;
        if (commit_s) begin
            mask_next_s = '0;
        end else if (last_s && !complete_s) begin
            // Incomplete configuration is discarded; shadow contents are stale.
            mask_next_s = '0;
        end else begin
            mask_next_s = mask_upd_s;
        end

        err_set_s  = (beat_s & ~stage_ok_s) | (last_s & ~complete_s);
        err_next_s = err_r;
        if (err_set_s) begin
            err_next_s = 1'b1;
        end else if (i_err_clr) begin
            err_next_s = 1'b0;
        end else begin
            err_next_s = err_r;
        end
    end

    // Control registers. Ready is the registered decode of the next state, so
    // it is 0 during reset and rises at the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
            mask_r  <= '0;
            ready_r <= 1'b0;
            epoch_r <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            mask_r  <= mask_next_s;
            ready_r <= (state_next_s == LOAD);
            epoch_r <= epoch_r + EPOCH_W'(commit_s);
            err_r   <= err_next_s;
        end
    end

    benes_sel_bank #(
        .SWITCH_NUM (SWITCH_NUM),
        .STAGE_NUM  (STAGE_NUM),
        .STAGE_W    (STAGE_W)
    ) u_module_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_module_s),
        .wr_stage   (cfg.i_cfg_stage),
        .wr_bits    (cfg.i_cfg_bits),
        .swap       (commit_s),
        .active_sel (o_module_select)
    );

    benes_sel_bank #(
        .SWITCH_NUM (SWITCH_NUM),
        .STAGE_NUM  (STAGE_NUM),
        .STAGE_W    (STAGE_W)
    ) u_slot_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_slot_s),
        .wr_stage   (cfg.i_cfg_stage),
        .wr_bits    (cfg.i_cfg_bits),
        .swap       (commit_s),
        .active_sel (o_slot_select)
    );

    assign cfg.o_cfg_ready = ready_r;
    assign o_epoch         = epoch_r;
    assign o_cfg_error     = err_r;

endmodule

// File: tb/tb_benes_sel_loader.sv
// Self-checking bench for benes_sel_loader: directed table, hand-written
// sequences and randomized loads compared against a transaction-level model.
module tb_benes_sel_loader;

    localparam int SW = 16;
    localparam int SN = 9;

    logic clk;
    logic rst_n;
    logic err_clr;
    logic [0:SN-1][SW-1:0] mod_sel;
    logic [0:SN-1][SW-1:0] slot_sel;
    logic [7:0] epoch;
    logic cfg_err;

    benes_sel_loader_if #(.SWITCH_NUM(SW), .STAGE_W(4)) cfg_if ();

    benes_sel_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg             (cfg_if),
        .o_module_select (mod_sel),
        .o_slot_select   (slot_sel),
        .o_epoch         (epoch),
        .o_cfg_error     (cfg_err),
        .i_err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_shadow [2][SN];
    logic [15:0] m_active [2][SN];
    bit          m_written[2][SN];
    bit          m_full;
    bit          m_err;
    bit          m_ready;
    int          m_epoch;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < SN; s++) begin
                m_shadow[t][s] = 16'h0000;
                m_active[t][s] = 16'h0000;
                m_written[t][s] = 1'b0;
            end
        m_full = 1'b0; m_err = 1'b0; m_ready = 1'b0; m_epoch = 0;
    endtask

    function automatic bit all_written();
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < SN; s++)
                if (!m_written[t][s]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_written();
        for (int t = 0; t < 2; t++)
            for (int s = 0; s < SN; s++) m_written[t][s] = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit tg, input int st, input logic [15:0] b,
                              input bit l, input bit cm, input bit cl);
        bit ev;
        ev = 1'b0;
        if (v && m_ready) begin
            if (st < SN) begin
                m_shadow[tg][st] = b;
                m_written[tg][st] = 1'b1;
            end else begin
                ev = 1'b1;
            end
            if (l) begin
                if (all_written()) m_full = 1'b1;
                else begin ev = 1'b1; clear_written(); end
            end
        end else if (m_full && cm) begin
            for (int t = 0; t < 2; t++)
                for (int s = 0; s < SN; s++) m_active[t][s] = m_shadow[t][s];
            m_epoch = (m_epoch + 1) % 256;
            clear_written();
            m_full = 1'b0;
        end
        if (ev) m_err = 1'b1;
        else if (cl) m_err = 1'b0;
        m_ready = !m_full;
    endtask

    task automatic check_all();
        logic [0:SN-1][SW-1:0] em;
        logic [0:SN-1][SW-1:0] es;
        for (int s = 0; s < SN; s++) begin
            em[s] = m_active[0][s];
            es[s] = m_active[1][s];
        end
        chk("model_ready", 160'(cfg_if.o_cfg_ready), 160'(m_ready));
        chk("model_error", 160'(cfg_err), 160'(m_err));
        chk("model_epoch", 160'(epoch), 160'(m_epoch[7:0]));
        chk("model_module_sel", 160'(mod_sel), 160'(em));
        chk("model_slot_sel", 160'(slot_sel), 160'(es));
    endtask

    // One clock: drive at negedge, edge, sample at following negedge.
    task automatic cycle(input bit v, input bit tg, input int st, input logic [15:0] b,
                         input bit l, input bit cm, input bit cl);
        cfg_if.i_cfg_valid  = v;
        cfg_if.i_cfg_target = tg;
        cfg_if.i_cfg_stage  = 4'(st);
        cfg_if.i_cfg_bits   = b;
        cfg_if.i_cfg_last   = l;
        cfg_if.i_commit     = cm;
        err_clr             = cl;
        @(posedge clk);
        @(negedge clk);
        model_step(v, tg, st, b, l, cm, cl);
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit v; bit tg; int st; logic [15:0] b; bit l; bit cm; bit cl;
        bit exp_ready; bit exp_err; int exp_epoch;
    } vec_t;

    vec_t tbl[8];

    logic [0:SN-1][SW-1:0] exp_m;
    logic [0:SN-1][SW-1:0] exp_s;
    int perm[18];

    initial begin
        rst_n = 1'b0;
        err_clr = 1'b0;
        cfg_if.i_cfg_valid = 1'b0; cfg_if.i_cfg_target = 1'b0; cfg_if.i_cfg_stage = 4'd0;
        cfg_if.i_cfg_bits = 16'h0000; cfg_if.i_cfg_last = 1'b0; cfg_if.i_commit = 1'b0;
        model_reset();

        // Table: bad stages, error clear priority, incomplete last, commit in LOAD
        tbl[0] = '{1'b1, 1'b0,  9, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[1] = '{1'b0, 1'b0,  0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 12, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0};
        tbl[3] = '{1'b0, 1'b0,  0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[4] = '{1'b1, 1'b0,  3, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[5] = '{1'b0, 1'b0,  0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[6] = '{1'b1, 1'b1,  0, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[7] = '{1'b0, 1'b0,  0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};

        // Reset state while held in reset
        repeat (3) @(negedge clk);
        chk("rst_ready", 160'(cfg_if.o_cfg_ready), 160'(1'b0));
        chk("rst_module_sel", 160'(mod_sel), 160'd0);
        chk("rst_slot_sel", 160'(slot_sel), 160'd0);
        chk("rst_epoch", 160'(epoch), 160'd0);
        chk("rst_error", 160'(cfg_err), 160'd0);
        rst_n = 1'b1;
        idle();
        chk("ready_after_reset", 160'(cfg_if.o_cfg_ready), 160'(1'b1));

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].tg, tbl[i].st, tbl[i].b, tbl[i].l, tbl[i].cm, tbl[i].cl);
            chk("tbl_ready", 160'(cfg_if.o_cfg_ready), 160'(tbl[i].exp_ready));
            chk("tbl_error", 160'(cfg_err), 160'(tbl[i].exp_err));
            chk("tbl_epoch", 160'(epoch), 160'(8'(tbl[i].exp_epoch)));
        end

        // Full load and commit with the fixed pattern
        for (int i = 0; i < 18; i++) begin
            if (i < 9) begin
                exp_m[i] = 16'h1111 * 16'(i + 1);
                cycle(1'b1, 1'b0, i, exp_m[i], 1'b0, 1'b0, 1'b0);
            end else begin
                exp_s[i-9] = 16'hA5A5 ^ 16'(i - 9);
                cycle(1'b1, 1'b1, i - 9, exp_s[i-9], i == 17, 1'b0, 1'b0);
            end
        end
        chk("full_ready_low", 160'(cfg_if.o_cfg_ready), 160'(1'b0));
        chk("full_sel_unchanged", 160'(mod_sel), 160'd0);
        cycle(1'b1, 1'b0, 0, 16'hDEAD, 1'b0, 1'b0, 1'b0);  // ignored while FULL
        chk("full_hold_ready", 160'(cfg_if.o_cfg_ready), 160'(1'b0));
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("commit_module_sel", 160'(mod_sel), 160'(exp_m));
        chk("commit_slot_sel", 160'(slot_sel), 160'(exp_s));
        chk("commit_epoch", 160'(epoch), 160'd1);
        chk("commit_ready", 160'(cfg_if.o_cfg_ready), 160'(1'b1));

        // Commit while the mask is half full is ignored
        for (int s = 0; s < SN; s++) cycle(1'b1, 1'b0, s, 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("load_commit_sel", 160'(mod_sel), 160'(exp_m));
        chk("load_commit_epoch", 160'(epoch), 160'd1);
        chk("load_commit_error", 160'(cfg_err), 160'd0);

        // Incomplete last: five beats then a last beat
        for (int s = 0; s < 5; s++) cycle(1'b1, 1'b1, s, 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5, 16'($urandom), 1'b1, 1'b0, 1'b0);
        chk("incomplete_error", 160'(cfg_err), 160'd1);
        chk("incomplete_ready", 160'(cfg_if.o_cfg_ready), 160'(1'b1));
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Recovery load with a bad-stage beat mid-stream; mask must survive it
        for (int i = 0; i < 18; i++) begin
            if (i == 10) begin
                cycle(1'b1, 1'b0, 9, 16'hFFFF, 1'b0, 1'b0, 1'b0);
                chk("bad_stage_error", 160'(cfg_err), 160'd1);
            end
            cycle(1'b1, i >= 9, i % 9, 16'($urandom), i == 17, 1'b0, 1'b0);
        end
        chk("bad_stage_mask_kept", 160'(cfg_if.o_cfg_ready), 160'(1'b0));
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b1, 1'b1);
        chk("recovery_epoch", 160'(epoch), 160'd2);
        chk("recovery_error_cleared", 160'(cfg_err), 160'd0);

        // 256 randomized loads and commits, checked every cycle against the model
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 18; i++) perm[i] = i;
            for (int i = 17; i > 0; i--) begin
                int j; int tmp;
                j = int'($urandom_range(i, 0));
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < 18; i++) begin
                if ($urandom_range(3, 0) == 0)
                    cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, $urandom_range(7, 0) == 0, 1'b0);
                if ($urandom_range(15, 0) == 0)  // rewrite of an earlier stage
                    cycle(1'b1, perm[0] >= 9, perm[0] % 9, 16'($urandom), 1'b0, 1'b0, 1'b0);
                cycle(1'b1, perm[i] >= 9, perm[i] % 9, 16'($urandom), i == 17, 1'b0, 1'b0);
            end
            for (int w = int'($urandom_range(2, 0)); w > 0; w--)
                cycle(1'b1, 1'($urandom), int'($urandom_range(15, 0)), 16'($urandom), 1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
            if (m_epoch == 0) chk("epoch_wrap", 160'(epoch), 160'd0);
        end
        chk("epoch_after_256", 160'(epoch), 160'd2);

        // Unconstrained fuzz
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(3, 0) != 0, 1'($urandom), int'($urandom_range(15, 0)), 16'($urandom),
                  $urandom_range(15, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0);

        // Reset mid-load: make sure a commit has happened, then 7 beats, then reset
        for (int i = 0; i < 18; i++) cycle(1'b1, i >= 9, i % 9, 16'($urandom) | 16'h0001, i == 17, 1'b0, 1'b0);
        idle();
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, i, 16'($urandom), 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_module_sel", 160'(mod_sel), 160'd0);
        chk("midrst_slot_sel", 160'(slot_sel), 160'd0);
        chk("midrst_epoch", 160'(epoch), 160'd0);
        chk("midrst_ready", 160'(cfg_if.o_cfg_ready), 160'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle();
        chk("midrst_ready_after", 160'(cfg_if.o_cfg_ready), 160'(1'b1));
        for (int i = 0; i < 17; i++) cycle(1'b1, i >= 9, i % 9, 16'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8, 16'($urandom), 1'b1, 1'b0, 1'b0);
        chk("midrst_prior_lost", 160'(cfg_if.o_cfg_ready), 160'(1'b0));
        cycle(1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("midrst_epoch_restart", 160'(epoch), 160'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
